// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge port between the fetch stage and instruction memory.
// The master side drives the request and address; the slave side returns the ack and read data.
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack port, parks one instruction on stall.
// Define FETCH_PERF_CNT_EN to add saturating fetch/redirect performance counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [31:0]         redirect_pc_i,
    fetch_unit_if.master        imem_io,
    output logic [31:0]         out_pc_o,
    output logic [31:0]         out_inst_o,
    output logic                out_valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_count_o,
    output logic [31:0]         redirect_count_o
`endif
);

    typedef enum logic {StReq, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        out_valid_q, out_valid_d;
    logic        accept;

    // Ack only counts while a request is actually outstanding.
    assign accept = (state_q == StReq) && imem_io.ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StReq;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_i) begin
            state_d = StReq;
        end else begin
            unique case (state_q)
                StReq:   if (imem_io.ack && stall_i) state_d = StHold;
                StHold:  if (!stall_i) state_d = StReq;
                default: state_d = StReq;
            endcase
        end
    end

    always_comb begin
        imem_io.req  = (state_q == StReq) && !rst;
        imem_io.addr = pc_q;
    end

    always_comb begin
        pc_d        = pc_q;
        hold_pc_d   = hold_pc_q;
        hold_inst_d = hold_inst_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_valid_d = out_valid_q;
        if (redirect_i) begin
            // Redirect wins over stall and kills any same-cycle ack data.
            pc_d        = redirect_pc_i;
            hold_pc_d   = '0;
            hold_inst_d = NOP_INST;
            out_pc_d    = redirect_pc_i;
            out_inst_d  = NOP_INST;
            out_valid_d = 1'b0;
        end else if (state_q == StReq) begin
            if (imem_io.ack) begin
                pc_d = pc_q + PC_STEP;
                if (stall_i) begin
                    hold_pc_d   = pc_q;
                    hold_inst_d = imem_io.rdata;
                end else begin
                    out_pc_d    = pc_q;
                    out_inst_d  = imem_io.rdata;
                    out_valid_d = 1'b1;
                end
            end else if (!stall_i) begin
                out_inst_d  = NOP_INST;
                out_valid_d = 1'b0;
            end
        end else if (!stall_i) begin
            out_pc_d    = hold_pc_q;
            out_inst_d  = hold_inst_q;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            hold_pc_q   <= '0;
            hold_inst_q <= NOP_INST;
            out_pc_q    <= '0;
            out_inst_q  <= NOP_INST;
            out_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_pc_o    = out_pc_q;
    assign out_inst_o  = out_inst_q;
    assign out_valid_o = out_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] redir_cnt_q, redir_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (accept && !redirect_i && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (redirect_i && (redir_cnt_q != 32'hFFFF_FFFF)) begin
            redir_cnt_d = redir_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign fetch_count_o    = fetch_cnt_q;
    assign redirect_count_o = redir_cnt_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit; memory model returns rdata = addr * 3 with ack on demand.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ack_en = 1'b0;
    logic [31:0] out_pc, out_inst;
    logic        out_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, redirect_count;
`endif

    int total = 0;
    int bad = 0;

    fetch_unit_if imem ();

    assign imem.ack   = ack_en;
    assign imem.rdata = imem.addr * 32'd3;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_io       (imem),
        .out_pc_o      (out_pc),
        .out_inst_o    (out_inst),
        .out_valid_o   (out_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count_o    (fetch_count),
        .redirect_count_o (redirect_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        //          stall redir rpc            ack req  pc             inst           valid
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h0,        1'b1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1,        32'h3,        1'b1};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1,        NOP,          1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1,        NOP,          1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h2,        32'h6,        1'b1};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h3,        32'h9,        1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'hC,        1'b1};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'hC,        1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h4,        32'hC,        1'b1};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h4,        32'hC,        1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h5,        32'hF,        1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h6,        32'h12,       1'b1};
        vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h7,        32'h15,       1'b1};
        vecs[13] = '{1'b1, 1'b1, 32'h40,       1'b1, 1'b1, 32'h40,       NOP,          1'b0};
        vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h40,       32'hC0,       1'b1};
        vecs[15] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h40,       NOP,          1'b0};
        vecs[16] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h40,       NOP,          1'b0};
        vecs[17] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, NOP,         1'b0};
        vecs[18] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h0,        1'b1};
        vecs[20] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1,        32'h3,        1'b1};

        // Reset state while rst is held.
        #2;
        chk("rst req", {31'b0, imem.req}, 32'h0);
        chk("rst pc", out_pc, 32'h0);
        chk("rst inst", out_inst, NOP);
        chk("rst valid", {31'b0, out_valid}, 32'h0);
        chk("rst addr", imem.addr, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            stall       = vecs[i].stall;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            ack_en      = vecs[i].ack;
            #1;
            chk($sformatf("v%0d req", i), {31'b0, imem.req}, {31'b0, vecs[i].exp_req});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d pc", i), out_pc, vecs[i].exp_pc);
            chk($sformatf("v%0d inst", i), out_inst, vecs[i].exp_inst);
            chk($sformatf("v%0d valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
        end
        chk("post wrap addr", imem.addr, 32'h2);

`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", fetch_count, 32'd13);
        chk("redirect_count", redirect_count, 32'd2);
`endif

        // Asynchronous reset mid-stream: outputs clear before any clock edge.
        stall    = 1'b0;
        redirect = 1'b0;
        ack_en   = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst pc", out_pc, 32'h0);
        chk("arst inst", out_inst, NOP);
        chk("arst valid", {31'b0, out_valid}, 32'h0);
        chk("arst req", {31'b0, imem.req}, 32'h0);
        chk("arst addr", imem.addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("arst fetch_count", fetch_count, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after arst pc", out_pc, 32'h0);
        chk("after arst valid", {31'b0, out_valid}, 32'h1);
        @(posedge clk);
        #1;
        chk("after arst pc2", out_pc, 32'h1);
        chk("after arst inst2", out_inst, 32'h3);
`ifdef FETCH_PERF_CNT_EN
        chk("after arst fetch_count", fetch_count, 32'd2);
        chk("after arst redirect_count", redirect_count, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline buffer and drives its in_pc/in_inst inputs.
- Owns the program counter and selects the next PC: sequential step or redirect from branch/jump resolution.
- Drives a request/acknowledge instruction-memory port, absorbs downstream stalls with a one-entry hold buffer, and inserts NOP bubbles when no instruction is available.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_STEP, 1, increment per fetched instruction (word-addressed memory).
- NOP_INST, 32'h0000_0000, instruction word emitted as a bubble.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit: hold outputs, fetch no new instruction into the outputs.
- redirect  in  1  taken branch/jump; flushes fetch.
- redirect_pc  in  32  target PC, valid when redirect=1.
- imem_req  out  1  fetch request; combinational, =1 iff state==S_REQ and rst=0.
- imem_addr  out  32  equals pc.
- imem_ack  in  1  imem_rdata valid for current imem_addr this cycle.
- imem_rdata  in  32  instruction word.
- out_pc  out  32  PC of presented instruction, to IF/ID in_pc.
- out_inst  out  32  presented instruction, to IF/ID in_inst.
- out_valid  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset (async, immediate): pc=RESET_PC, state=S_REQ, out_pc=0, out_inst=NOP_INST, out_valid=0, hold buffer cleared.
- States:
  - S_REQ: request outstanding on pc.
  - S_HOLD: an instruction is parked in the hold buffer, waiting for stall to drop; no request.
- Priority per cycle: redirect > ack/hold handling.
- Redirect (any state, stall ignored):
  - pc <= redirect_pc; state <= S_REQ; hold buffer discarded; any same-cycle ack data discarded.
  - out_inst <= NOP_INST, out_valid <= 0, out_pc <= redirect_pc.
- S_REQ, ack=1, stall=0: out_pc <= pc, out_inst <= imem_rdata, out_valid <= 1; pc <= pc+PC_STEP; stay S_REQ.
- S_REQ, ack=1, stall=1: hold_pc <= pc, hold_inst <= imem_rdata; pc <= pc+PC_STEP; outputs unchanged; go S_HOLD.
- S_REQ, ack=0, stall=0: out_inst <= NOP_INST, out_valid <= 0; out_pc unchanged; pc unchanged.
- S_REQ, ack=0, stall=1: all outputs unchanged.
- S_HOLD, stall=1: everything unchanged; imem_req=0.
- S_HOLD, stall=0: outputs <= hold buffer, out_valid <= 1; go S_REQ. Next request starts the following cycle; the pc already points at the next instruction.
- Latency:
  - With zero-wait memory (ack same cycle) and no stall: one instruction per cycle.
  - First instruction appears on the outputs at the first posedge after rst deasserts.
- Arithmetic: pc+PC_STEP is 32-bit modulo; 32'hFFFF_FFFF+1 wraps to 0 with no flag.
- Memory contract:
  - Memory responds to the address presented in the same cycle.
  - The address may change when no ack was given (abort on redirect is permitted).
  - ack while imem_req=0 is ignored.
- Stall never drops an acked instruction; at most one instruction is buffered.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output ports fetch_count[31:0] (increments on every accepted ack not killed by redirect) and redirect_count[31:0] (increments on every redirect cycle).
  - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset release, ack tied 1, rdata=pc*3, stall=0 -> out_pc 0,1,2,3 on successive cycles; out_inst 0,3,6,9; out_valid=1 from first posedge.
- ack low cycles 2-3 -> out_valid=0 and out_inst=NOP_INST for those cycles; pc does not advance; sequence resumes with no PC gap.
- stall=1 for 3 cycles while ack=1 at pc=5 -> one instruction (pc 5) parked; outputs frozen; imem_req=0 in S_HOLD; on stall release out_pc=5, then 6, 7 follow.
- redirect=1, redirect_pc=0x40, with stall=1 and ack=1 at pc=8 -> next out_valid=0, out_pc=0x40; pc 8 never emitted; next valid out_pc=0x40.
- Set pc near wrap via redirect_pc=32'hFFFF_FFFF -> out_pc FFFF_FFFF, then 0; rst pulsed mid-stream -> outputs reset immediately without a clock edge.
- With FETCH_PERF_CNT_EN: 10 fetches plus 2 redirects -> fetch_count=10 (killed fetches excluded), redirect_count=2.
